// File: rtl/fc_mac_array_if.sv
// Bus bundle for the fully connected MAC array: control, the beat stream
// in, and the result port out. The engine uses the slave modport.
interface fc_mac_array_if #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int BW    = 16,
  parameter int AW    = 32,
  parameter int OW    = 8,
  parameter int LEN_W = 10,
  parameter int SH_W  = 5
);
  logic                   start;
  logic                   abort;
  logic [LEN_W-1:0]       len;
  logic [SH_W-1:0]        shift;
  logic                   relu_en;
  logic [LANES*BW-1:0]    bias_i;
  logic                   in_valid;
  logic                   in_ready;
  logic [DW-1:0]          data_i;
  logic [LANES*WW-1:0]    weight_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*AW-1:0]    acc_o;
  logic [LANES*OW-1:0]    q_o;
  logic                   busy;

  modport master (
    output start, abort, len, shift, relu_en, bias_i,
    output in_valid, data_i, weight_i, out_ready,
    input  in_ready, out_valid, acc_o, q_o, busy
  );

  modport slave (
    input  start, abort, len, shift, relu_en, bias_i,
    input  in_valid, data_i, weight_i, out_ready,
    output in_ready, out_valid, acc_o, q_o, busy
  );
endinterface

// File: rtl/fc_mac_array.sv
// Multi-lane MAC engine for the FC layer. Every lane starts from its bias,
// accumulates len products of the shared activation with its own weight
// through a two-stage (multiply, add) pipeline, and exposes the raw
// accumulator plus a rounded/shifted/ReLU'd/saturated result.
module fc_mac_array #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int BW    = 16,
  parameter int AW    = 32,
  parameter int OW    = 8,
  parameter int LEN_W = 10,
  parameter int SH_W  = 5
) (
  input logic           clk,
  input logic           rst_n,
  fc_mac_array_if.slave bus
);
  localparam int PW     = DW + WW;
  localparam int QMAX_I = (1 << (OW - 1)) - 1;
  localparam int QMIN_I = -(1 << (OW - 1));

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_count;
  logic [SH_W-1:0]       r_shift;
  logic                  r_relu;
  logic                  r_prod_vld;
  logic signed [PW-1:0]  r_prod [LANES];
  logic signed [AW-1:0]  r_acc  [LANES];

  logic                  w_accept;
  logic                  w_load;
  logic [LEN_W-1:0]      w_count_nxt;

  // Round half up, arithmetic shift, optional ReLU, then clamp to OW bits.
  // The extra top bit keeps the rounding add from overflowing.
  function automatic logic signed [OW-1:0] requant(
    input logic signed [AW-1:0] acc,
    input logic [SH_W-1:0]      sh,
    input logic                 relu
  );
    logic signed [AW:0] rnd;
    logic signed [AW:0] r;
    logic signed [AW:0] s;
    logic signed [AW:0] qmax;
    logic signed [AW:0] qmin;
    rnd = '0;
    if (sh != '0) rnd = (AW+1)'(1) << (sh - SH_W'(1));
    r    = (AW+1)'(acc) + rnd;
    s    = r >>> sh;
    qmax = (AW+1)'(QMAX_I);
    qmin = (AW+1)'(QMIN_I);
    if (relu && (s < 0)) s = '0;
    if (s > qmax)      s = qmax;
    else if (s < qmin) s = qmin;
    return OW'(s);
  endfunction

  assign w_accept    = r_in_ready & bus.in_valid;
  assign w_load      = (r_state == S_IDLE) & bus.start;
  assign w_count_nxt = r_count + LEN_W'(1);

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

  // Control FSM: beat counting, stage-1 valid, handshake flags; abort wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_len       <= '0;
      r_count     <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_prod_vld  <= 1'b0;
    end else if (bus.abort) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_count     <= '0;
      r_prod_vld  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_prod_vld <= 1'b0;
          if (bus.start) begin
            r_len   <= bus.len;
            r_shift <= bus.shift;
            r_relu  <= bus.relu_en;
            r_count <= '0;
            r_busy  <= 1'b1;
            if (bus.len == '0) begin
              r_state <= S_DRAIN;
            end else begin
              r_state    <= S_ACC;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_ACC: begin
          r_prod_vld <= w_accept;
          if (w_accept) begin
            r_count <= w_count_nxt;
            if (w_count_nxt == r_len) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_prod_vld  <= 1'b0;
          r_state     <= S_OUT;
          r_out_valid <= 1'b1;
        end
        default: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
      endcase
    end
  end

  // Datapath: stage 1 multiplies the accepted beat, stage 2 accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        r_prod[k] <= '0;
        r_acc[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (w_accept && !bus.abort)
          r_prod[k] <= $signed(bus.data_i) * $signed(bus.weight_i[k*WW +: WW]);
        if (bus.abort)
          r_acc[k] <= '0;
        else if (w_load)
          r_acc[k] <= AW'($signed(bus.bias_i[k*BW +: BW]));
        else if (r_prod_vld)
          r_acc[k] <= r_acc[k] + AW'(r_prod[k]);
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign bus.acc_o[k*AW +: AW] = r_acc[k];
    assign bus.q_o[k*OW +: OW]   = requant(r_acc[k], r_shift, r_relu);
  end

endmodule
